// File: rtl/noc_eject_sink_pkg.sv
// Shared definitions for the NoC ejection sink: packet field offsets and FSM states.
// Field offsets are functions so every file derives them from the same A_W/D_W.
package noc_eject_sink_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Packet layout, MSB first: valid, flag, addr[A_W], data[D_W].
  function automatic int valid_bit(input int a_w, input int d_w);
    return a_w + d_w + 1;
  endfunction

  function automatic int flag_bit(input int a_w, input int d_w);
    return a_w + d_w;
  endfunction

  function automatic int addr_msb(input int a_w, input int d_w);
    return a_w + d_w - 1;
  endfunction

  function automatic int addr_lsb(input int d_w);
    return d_w;
  endfunction

  function automatic int data_msb(input int d_w);
    return d_w - 1;
  endfunction

endpackage

// File: rtl/noc_eject_sink_fifo.sv
// Small synchronous FIFO whose head is readable in the same cycle (no read latency).
// A push into a full FIFO is honoured only when a pop frees the slot that cycle.
module noc_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 33
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [W-1:0]               wdata_i,
  output logic [W-1:0]               rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q;
  logic [PW-1:0] rd_q;
  logic [CW-1:0] cnt_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rd_q];
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= wdata_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (do_pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/noc_eject_sink.sv
// Ejection endpoint of a deflection-NoC client port: accepts packets addressed to this
// node into a FIFO, drains them over valid/ready, and keeps receive statistics.
module noc_eject_sink
  import noc_eject_sink_pkg::*;
#(
  parameter int N     = 2,
  parameter int D_W   = 32,
  parameter int A_W   = $clog2(N) + 1,
  parameter int DEPTH = 4,
  parameter int LIMIT = 16,
  parameter int posx  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ce,
  input  logic [A_W+D_W+1:0]   o,
  output logic                 o_ack,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic [D_W:0]         rx_data,
  output logic [15:0]          rx_count,
  output logic [15:0]          miss_count,
  output logic [D_W-1:0]       checksum,
  output logic                 done,
  output logic                 err
);

  localparam int VALID_BIT = valid_bit(A_W, D_W);
  localparam int FLAG_BIT  = flag_bit(A_W, D_W);
  localparam int ADDR_MSB  = addr_msb(A_W, D_W);
  localparam int ADDR_LSB  = addr_lsb(D_W);
  localparam int DATA_MSB  = data_msb(D_W);
  localparam logic [A_W-1:0] POS_A = A_W'(posx);
  localparam logic [A_W-1:0] N_A   = A_W'(N);

  logic             pkt_valid;
  logic             pkt_flag;
  logic [A_W-1:0]   pkt_addr;
  logic [D_W-1:0]   pkt_data;
  logic             hit;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;

  state_e         state_q, state_d;
  logic [15:0]    rx_count_q, rx_count_d;
  logic [15:0]    miss_count_q, miss_count_d;
  logic [D_W-1:0] checksum_q, checksum_d;
  logic           err_q, err_d;

  assign pkt_valid = o[VALID_BIT];
  assign pkt_flag  = o[FLAG_BIT];
  assign pkt_addr  = o[ADDR_MSB:ADDR_LSB];
  assign pkt_data  = o[DATA_MSB:0];
  assign hit       = pkt_valid & (pkt_addr == POS_A);
  assign pop       = ce & rx_valid & rx_ready;
  assign rx_valid  = ~fifo_empty;

  noc_sync_fifo #(
    .DEPTH (DEPTH),
    .W     (D_W + 1)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (o_ack),
    .pop_i   (pop),
    .wdata_i ({pkt_flag, pkt_data}),
    .rdata_o (rx_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // RUN leaves as soon as the edge that brings rx_count to LIMIT has been taken.
  always_comb begin
    state_d = state_q;
    if (ce) begin
      unique case (state_q)
        RUN:     if (rx_count_d >= 16'(LIMIT)) state_d = DRAIN;
        DRAIN:   if (fifo_count == '0) state_d = DONE;
        DONE:    state_d = DONE;
        default: state_d = RUN;
      endcase
    end
  end

  // A full FIFO still accepts when the head leaves this cycle.
  always_comb begin
    o_ack = ce & hit & (~fifo_full | pop) & (state_q == RUN);
    done  = (state_q == DONE);
  end

  always_comb begin
    rx_count_d   = rx_count_q;
    miss_count_d = miss_count_q;
    checksum_d   = checksum_q;
    err_d        = err_q;
    if (o_ack) begin
      if (rx_count_q != 16'hFFFF) rx_count_d = rx_count_q + 16'd1;
      checksum_d = checksum_q + pkt_data;
    end
    if (ce && pkt_valid) begin
      if (pkt_addr != POS_A && miss_count_q != 16'hFFFF) miss_count_d = miss_count_q + 16'd1;
      if (pkt_addr >= N_A) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_count_q   <= '0;
      miss_count_q <= '0;
      checksum_q   <= '0;
      err_q        <= 1'b0;
    end else if (ce) begin
      rx_count_q   <= rx_count_d;
      miss_count_q <= miss_count_d;
      checksum_q   <= checksum_d;
      err_q        <= err_d;
    end
  end

  assign rx_count   = rx_count_q;
  assign miss_count = miss_count_q;
  assign checksum   = checksum_q;
  assign err        = err_q;

endmodule
